// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: req/ack data-memory access with lane alignment and load extension.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_M,
    input  logic          memread_M,
    input  logic          memwrite_M,
    input  logic [1:0]    memsize_M,
    input  logic          memunsigned_M,
    input  logic          regwrite_M,
    input  logic [DW-1:0] aluresult_M,
    input  logic [DW-1:0] writedata_M,
    input  logic [4:0]    writereg_M,
    output logic [DW-1:0] aluresult_out,
    output logic [DW-1:0] readdata_out,
    output logic [4:0]    writereg_out,
    output logic          regwrite_out,
    output logic          stall_M,
    output logic          misalign_M,
    output logic          bus_err,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d, we_q, we_d;
    logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]    be_q, be_d;
    logic [1:0]    lane_q, lane_d;
    logic          byte_q, byte_d, half_q, half_d, uns_q, uns_d;
    logic          bus_err_q, bus_err_d, to_q, to_d;

    logic          memop, is_byte, is_half, is_word, misaligned, issue;
    logic [3:0]    be_c;
    logic [DW-1:0] wdata_c, shifted, ext;

    assign memop      = valid_M & (memread_M | memwrite_M);
    assign is_byte    = (memsize_M == 2'b00);
    assign is_half    = (memsize_M == 2'b01);
    assign is_word    = memsize_M[1];
    assign misaligned = memop & ((is_half & aluresult_M[0]) | (is_word & (aluresult_M[1:0] != 2'b00)));
    assign issue      = (state_q == IDLE) & memop & ~misaligned;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = writedata_M;
        if (is_byte) begin
            be_c    = 4'b0001 << aluresult_M[1:0];
            wdata_c = {4{writedata_M[7:0]}};
        end else if (is_half) begin
            be_c    = 4'b0011 << {aluresult_M[1], 1'b0};
            wdata_c = {2{writedata_M[15:0]}};
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        lane_d    = lane_q;
        byte_d    = byte_q;
        half_d    = half_q;
        uns_d     = uns_q;
        to_d      = to_q;
        bus_err_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = memwrite_M & ~memread_M;
                    addr_d  = {aluresult_M[DW-1:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    lane_d  = aluresult_M[1:0];
                    byte_d  = is_byte;
                    half_d  = is_half;
                    uns_d   = memunsigned_M;
                    to_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = dmem_rdata;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    // Abandon the access: no data, no register write.
                    state_d   = DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    to_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                to_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            be_q      <= '0;
            lane_q    <= '0;
            byte_q    <= 1'b0;
            half_q    <= 1'b0;
            uns_q     <= 1'b0;
            to_q      <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_q      <= be_d;
            lane_q    <= lane_d;
            byte_q    <= byte_d;
            half_q    <= half_d;
            uns_q     <= uns_d;
            to_q      <= to_d;
            bus_err_q <= bus_err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign shifted = rdata_q >> {lane_q, 3'b000};

    always_comb begin
        ext = rdata_q;
        if (byte_q) begin
            ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
        end else if (half_q) begin
            ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
        end
    end

    assign aluresult_out = aluresult_M;
    assign writereg_out  = writereg_M;
    assign readdata_out  = (state_q == DONE) ? ext : '0;
    assign stall_M       = ~reset & (issue | (state_q == BUSY));
    assign misalign_M    = ~reset & (state_q == IDLE) & misaligned;
    assign regwrite_out  = regwrite_M & valid_M & ~stall_M & ~misaligned & ~to_q;
    assign bus_err       = bus_err_q;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores/misaligned ops, reset during an access,
// and (when MEM_TIMEOUT_EN is defined) the bus timeout path.
module tb_mem_access_stage;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_M = 1'b0, memread_M = 1'b0, memwrite_M = 1'b0;
    logic [1:0]  memsize_M = 2'b00;
    logic        memunsigned_M = 1'b0, regwrite_M = 1'b0;
    logic [31:0] aluresult_M = '0, writedata_M = '0;
    logic [4:0]  writereg_M = '0;
    logic [31:0] aluresult_out, readdata_out;
    logic [4:0]  writereg_out;
    logic        regwrite_out, stall_M, misalign_M, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    mem_access_stage #(.DW(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid_M(valid_M), .memread_M(memread_M),
        .memwrite_M(memwrite_M), .memsize_M(memsize_M), .memunsigned_M(memunsigned_M),
        .regwrite_M(regwrite_M), .aluresult_M(aluresult_M), .writedata_M(writedata_M),
        .writereg_M(writereg_M), .aluresult_out(aluresult_out), .readdata_out(readdata_out),
        .writereg_out(writereg_out), .regwrite_out(regwrite_out), .stall_M(stall_M),
        .misalign_M(misalign_M), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, rd;
        logic [4:0]  wr;
        logic        rw, mis, berr;
        int          stalls;
    } ret_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        we;
    } bus_t;

    ret_t ret_q[$];
    bus_t bus_q[$];
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Bus responder: ack after ack_wait extra BUSY cycles with resp_data
    int          ack_wait = 0, wcnt = 0;
    logic [31:0] resp_data = '0;
    logic        bus_manual = 1'b0;

    always @(negedge clk) begin
        if (!bus_manual) begin
            if (dmem_req && !dmem_ack) begin
                if (wcnt == ack_wait) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = resp_data;
                end else begin
                    wcnt++;
                end
            end else begin
                dmem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    // Retire monitor: an instruction leaves MEM when valid and not stalled
    int   stall_cnt = 0;
    ret_t e;
    always @(negedge clk) begin
        if (reset || !valid_M) begin
            stall_cnt = 0;
        end else if (stall_M) begin
            stall_cnt++;
        end else begin
            if (ret_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = ret_q.pop_front();
                chk("aluresult_out", aluresult_out, e.alu);
                chk("readdata_out", readdata_out, e.rd);
                chk("writereg_out", 32'(writereg_out), 32'(e.wr));
                chk("regwrite_out", 32'(regwrite_out), 32'(e.rw));
                chk("misalign_M", 32'(misalign_M), 32'(e.mis));
                chk("bus_err", 32'(bus_err), 32'(e.berr));
                chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            end
            stall_cnt = 0;
        end
    end

    // Bus monitor: checks the request fields on the first BUSY cycle
    logic req_prev = 1'b0;
    bus_t b;
    always @(negedge clk) begin
        if (!reset && dmem_req && !req_prev) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_req", 32'd1, 32'd0);
            end else begin
                b = bus_q.pop_front();
                chk("dmem_addr", dmem_addr, b.addr);
                chk("dmem_be", 32'(dmem_be), 32'(b.be));
                chk("dmem_we", 32'(dmem_we), 32'(b.we));
                chk("dmem_wdata", dmem_wdata, b.wdata);
            end
        end
        req_prev = dmem_req;
    end

    // Drives one instruction (called #1 after a posedge) and waits until it leaves MEM
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] wreg, input int waits, input logic [31:0] resp,
                      input logic [31:0] exp_rd, input logic [3:0] exp_be, input logic exp_we,
                      input logic [31:0] exp_wdata, input int exp_stalls, input logic exp_mis,
                      input logic exp_rw, input logic exp_berr);
        ret_t r;
        bus_t bb;
        logic st;
        int   guard;
        valid_M = 1'b1; memread_M = rd; memwrite_M = wr; memsize_M = sz;
        memunsigned_M = uns; regwrite_M = rw; aluresult_M = addr; writedata_M = wd;
        writereg_M = wreg; ack_wait = waits; resp_data = resp;
        r.alu = addr; r.rd = exp_rd; r.wr = wreg; r.rw = exp_rw; r.mis = exp_mis;
        r.berr = exp_berr; r.stalls = exp_stalls;
        ret_q.push_back(r);
        if (!exp_mis && (rd || wr)) begin
            bb.addr = {addr[31:2], 2'b00}; bb.be = exp_be; bb.we = exp_we; bb.wdata = exp_wdata;
            bus_q.push_back(bb);
        end
        guard = 0;
        do begin
            @(negedge clk);
            st = stall_M;
            @(posedge clk);
            #1;
            guard++;
        end while (st && guard < 300);
        if (guard >= 300) chk("op_retire_timeout", 32'd1, 32'd0);
    endtask

    task automatic bubble(input int n);
        valid_M = 1'b0; memread_M = 1'b0; memwrite_M = 1'b0; regwrite_M = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state; combinational passthroughs follow inputs during reset
        valid_M = 1'b1; regwrite_M = 1'b1; aluresult_M = 32'h0000_0055; writereg_M = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_stall_M", 32'(stall_M), 32'd0);
        chk("rst_misalign_M", 32'(misalign_M), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_readdata", readdata_out, 32'd0);
        chk("rst_aluresult", aluresult_out, 32'h0000_0055);
        chk("rst_writereg", 32'(writereg_out), 32'd9);
        chk("rst_regwrite", 32'(regwrite_out), 32'd1);
        valid_M = 1'b0; regwrite_M = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        //  rd    wr    sz     uns   rw    addr          wd            wr  wt resp          exp_rd        be       we    wdata         st mis   rw    berr
        op(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0100, 32'h0,        5'd8, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,        4, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0103, 32'h0,        5'd9, 0, 32'h8012_3456, 32'hFFFF_FF80, 4'b1000, 1'b0, 32'h0,        2, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0103, 32'h0,        5'd9, 1, 32'h8012_3456, 32'h0000_0080, 4'b1000, 1'b0, 32'h0,        3, 1'b0, 1'b1, 1'b0);
        op(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 5'd0, 0, 32'h0,        32'h0,        4'b1100, 1'b1, 32'hABCD_ABCD, 2, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0101, 32'h0,        5'd4, 0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b0);
        op(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h1234_5678, 32'h0,        5'd3, 0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        0, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_0202, 32'h0,        5'd5, 0, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1100, 1'b0, 32'h0,        2, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0000_0202, 32'h0,        5'd5, 0, 32'h8001_7FFF, 32'h0000_8001, 4'b1100, 1'b0, 32'h0,        2, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_0200, 32'h0,        5'd6, 3, 32'h8001_7FFF, 32'h0000_7FFF, 4'b0011, 1'b0, 32'h0,        5, 1'b0, 1'b1, 1'b0);
        op(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0301, 32'h0000_00A5, 5'd0, 0, 32'h0,        32'h0,        4'b0010, 1'b1, 32'hA5A5_A5A5, 2, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 5'd0, 1, 32'h0,        32'h0,        4'b1111, 1'b1, 32'hCAFE_F00D, 3, 1'b0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h0000_0203, 32'h0,        5'd7, 0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b0);
        op(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0102, 32'h0,        5'd0, 0, 32'h0,        32'h0,        4'b0000, 1'b0, 32'h0,        0, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0011, 5'd2, 0, 32'h0000_0042, 32'h0000_0042, 4'b0001, 1'b0, 32'h1111_1111, 2, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0000_0001, 32'h0,        5'd2, 0, 32'h0000_7F00, 32'h0000_007F, 4'b0010, 1'b0, 32'h0,        2, 1'b0, 1'b1, 1'b0);

        // Not valid: no request may appear
        valid_M = 1'b0; memread_M = 1'b1; memsize_M = 2'b10; aluresult_M = 32'h0000_0600;
        repeat (3) @(posedge clk);
        #1;
        chk("invalid_no_req", 32'(dmem_req), 32'd0);
        chk("invalid_no_stall", 32'(stall_M), 32'd0);
        bubble(1);

        // Reset in the middle of an access, then a stray ack
        bus_manual = 1'b1;
        valid_M = 1'b1; memread_M = 1'b1; memwrite_M = 1'b0; memsize_M = 2'b10;
        regwrite_M = 1'b1; aluresult_M = 32'h0000_0500; writereg_M = 5'd10;
        bus_q.push_back('{addr: 32'h0000_0500, wdata: 32'h0, be: 4'b1111, we: 1'b0});
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy_req", 32'(dmem_req), 32'd1);
        reset = 1'b1; valid_M = 1'b0; memread_M = 1'b0; regwrite_M = 1'b0;
        #1;
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_dmem_be", 32'(dmem_be), 32'd0);
        chk("midrst_stall", 32'(stall_M), 32'd0);
        chk("midrst_readdata", readdata_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_readdata", readdata_out, 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall_M), 32'd0);
        @(posedge clk); #1;
        chk("late_ack_readdata2", readdata_out, 32'd0);
        bus_manual = 1'b0;

        // Normal access after reset recovery
        op(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0700, 32'h0, 5'd11, 0, 32'h0102_0304, 32'h0102_0304, 4'b1111, 1'b0, 32'h0, 2, 1'b0, 1'b1, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: four BUSY cycles, then DONE with bus_err and no register write
        bus_manual = 1'b1;
        dmem_ack = 1'b0;
        op(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0000_0800, 32'h0, 5'd12, 0, 32'h0, 32'h0, 4'b1111, 1'b0, 32'h0, 5, 1'b0, 1'b0, 1'b1);
        chk("timeout_req_dropped", 32'(dmem_req), 32'd0);
        bus_manual = 1'b0;
`endif

        bubble(3);
        chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage of the 5-stage MIPS core.
- Sits between the EX/MEM latch and the MEM/WB latch, and produces the aluresult/readdata/writereg triple that the MEM/WB latch registers.
- Drives a req/ack data-memory bus with variable latency, performs byte/halfword/word alignment, lane selection and sign/zero extension, and stalls upstream stages while an access is outstanding.

Parameters:
- DW, 32, data/address width (fixed 32 for MIPS; byte-enable logic assumes DW=32).
- TIMEOUT, 64, max cycles waiting for dmem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_M  in  1  instruction in MEM is valid
- memread_M  in  1  load
- memwrite_M  in  1  store
- memsize_M  in  2  00 byte, 01 half, 10/11 word
- memunsigned_M  in  1  zero-extend load (lbu/lhu)
- regwrite_M  in  1  instruction writes register file
- aluresult_M  in  32  effective address / ALU result
- writedata_M  in  32  store data (rt)
- writereg_M  in  5  destination register
- aluresult_out  out  32  to MEM/WB latch
- readdata_out  out  32  extended load data to MEM/WB latch
- writereg_out  out  5  to MEM/WB latch
- regwrite_out  out  1  qualified register write
- stall_M  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- misalign_M  out  1  address-error pulse
- bus_err  out  1  timeout pulse (0 when feature off)
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables, lane i = bits [8i+7:8i]
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  transfer complete

Behaviour:
- memop = valid_M & (memread_M | memwrite_M). Loads take priority if both read and write are set.
- misaligned = half & addr[0], or word & addr[1:0]!=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, memop & ~misaligned: register addr/be/we/wdata, go to BUSY, stall_M=1.
  - IDLE, misaligned: misalign_M=1 for that cycle, no request, stall_M=0, regwrite_out=0.
  - BUSY: dmem_req=1, stall_M=1. Bus fields held stable until ack.
  - BUSY on dmem_ack: capture dmem_rdata, go to DONE.
  - DONE: stall_M=0; readdata_out = extended captured data; next state IDLE. The held instruction is not re-issued.
- Minimum access latency is 3 cycles (detect, ack, DONE). Each extra cycle without ack adds 1.
- Non-memory instructions pass through with 0 stall.
- Little-endian lanes: lane = addr[1:0].
  - Byte: be=0001<<lane; wdata={4{wd[7:0]}}.
  - Half: be=0011<<(2*addr[1]); wdata={2{wd[15:0]}}.
  - Word: be=1111; wdata=wd.
- Load extension: selected byte or half is sign-extended, or zero-extended when memunsigned_M=1. Word is passed unchanged.
- readdata_out=0 except in DONE.
- aluresult_out and writereg_out are combinational passthrough.
- regwrite_out = regwrite_M & valid_M & ~stall_M & ~misaligned.
- dmem_ack outside BUSY is ignored.
- Reset (async, any state): state=IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; captured data=0; stall_M=0, misalign_M=0, bus_err=0. A late ack after reset is ignored.
- Reset values of combinational outputs: readdata_out=0; aluresult_out, writereg_out and regwrite_out follow their inputs per the rules above.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 without ack: drop dmem_req, pulse bus_err 1 cycle, go to DONE with captured data=0 and regwrite_out forced 0.
  - An ack in the timeout cycle wins over the timeout.
- Undefined: no counter; BUSY waits indefinitely; bus_err tied 0.

Test Plan:
- lw at 0x100, ack after 2 wait cycles, rdata=0xDEADBEEF -> stall_M high 4 cycles; DONE readdata_out=0xDEADBEEF, regwrite_out=1; dmem_addr=0x100, be=1111.
- lb at 0x103, rdata=0x80xxxxxx, then lbu same address -> readdata_out 0xFFFFFF80 then 0x00000080.
- sh at 0x102, wd=0x1234ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, regwrite_out=0.
- lw at 0x101 -> misalign_M=1 one cycle, dmem_req never asserts, stall_M=0, regwrite_out=0.
- Reset asserted in BUSY, ack arrives 1 cycle after deassert -> dmem_req=0 immediately, state IDLE, ack ignored, readdata_out=0.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> dmem_req drops after 4 BUSY cycles, bus_err pulses once, readdata_out=0, stall_M releases next cycle.
